// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command receiver.
//   - ASCII key codes recognised by the decoder
//   - bit positions of each command in the one-hot command byte
//   - receive FSM state encoding
//   - decode_key(): maps a received byte to its one-hot command (0x00 if unknown)
package uart_cmd_pkg;

    localparam logic [7:0] KEY_F     = 8'h66;
    localparam logic [7:0] KEY_A     = 8'h61;
    localparam logic [7:0] KEY_SPACE = 8'h20;
    localparam logic [7:0] KEY_S     = 8'h73;
    localparam logic [7:0] KEY_1     = 8'h31;
    localparam logic [7:0] KEY_2     = 8'h32;
    localparam logic [7:0] KEY_3     = 8'h33;
    localparam logic [7:0] KEY_L     = 8'h6C;

    localparam int CMD_FLAP1 = 0;
    localparam int CMD_QUIT  = 1;
    localparam int CMD_PAUSE = 2;
    localparam int CMD_S     = 3;
    localparam int CMD_HARD  = 4;
    localparam int CMD_MED   = 5;
    localparam int CMD_EASY  = 6;
    localparam int CMD_FLAP2 = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic logic [7:0] decode_key(input logic [7:0] key);
        logic [7:0] c;
        c = 8'h00;
        case (key)
            KEY_F:     c[CMD_FLAP1] = 1'b1;
            KEY_A:     c[CMD_QUIT]  = 1'b1;
            KEY_SPACE: c[CMD_PAUSE] = 1'b1;
            KEY_S:     c[CMD_S]     = 1'b1;
            KEY_3:     c[CMD_HARD]  = 1'b1;
            KEY_2:     c[CMD_MED]   = 1'b1;
            KEY_1:     c[CMD_EASY]  = 1'b1;
            KEY_L:     c[CMD_FLAP2] = 1'b1;
            default:   c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver core: input synchronizer, receive FSM and byte output.
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rxd        asynchronous serial line, idles high
//   byte_o     last correctly framed byte
//   byte_valid one-cycle pulse when byte_o updates
//   frame_err  one-cycle pulse when the stop bit is sampled low
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit; high there means a glitch
// DATA  | sampling 8 data bits LSB first at one-bit intervals
// STOP  | sampling the stop bit; high = good byte, low = frame error
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] byte_o,
    output logic       byte_valid,
    output logic       frame_err
);

    // Bit timer counts down and fires at zero; loading HALF/FULL gives the
    // same sample instants as counting up from zero to CLKS_PER_BIT/2-1 or
    // CLKS_PER_BIT-1.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             rx_s1;
    logic             rx_s;
    logic             rx_d;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    logic             cnt_tc;
    logic             cnt_ld;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             idx_clr;
    logic             shift_en;
    logic             done_ok;
    logic             done_err;

    assign cnt_tc = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s  <= rx_s1;
            rx_d  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (rx_d && !rx_s) state_nxt = ST_START;
            ST_START: if (cnt_tc)        state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt_tc && idx == 3'd7) state_nxt = ST_STOP;
            ST_STOP:  if (cnt_tc)        state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_ld     = 1'b0;
        cnt_ld_val = CNT_FULL;
        idx_clr    = 1'b0;
        shift_en   = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_ld     = 1'b1;
                cnt_ld_val = CNT_HALF;
                idx_clr    = 1'b1;
            end
            ST_START: begin
                if (cnt_tc && !rx_s) begin
                    cnt_ld  = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_tc) begin
                    cnt_ld   = 1'b1;
                    shift_en = 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_tc) begin
                    done_ok  = rx_s;
                    done_err = !rx_s;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 3'd0;
            shift      <= 8'h00;
            byte_o     <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (cnt_ld) cnt <= cnt_ld_val;
            else        cnt <= cnt - CNT_W'(1);

            if (idx_clr)       idx <= 3'd0;
            else if (shift_en) idx <= idx + 3'd1;

            if (shift_en) shift[idx] <= rx_s;
            if (done_ok)  byte_o     <= shift;

            byte_valid <= done_ok;
            frame_err  <= done_err;
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Serial command front end: UART receiver plus key decoder and a command
// hold stage that presents each accepted key for exactly one game tick.
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rxd        asynchronous serial line, idles high
//   tick       single-cycle game-tick strobe
//   byte_o     last correctly framed byte
//   byte_valid one-cycle pulse when byte_o updates
//   frame_err  one-cycle pulse on a low stop bit
//   cmd        one-hot command, updated only in the cycle after a tick
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       tick,
    output logic [7:0] byte_o,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] cmd
);

    logic [7:0] pending;
    logic [7:0] decode_now;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .byte_o     (byte_o),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign decode_now = byte_valid ? decode_key(byte_o) : 8'h00;

    // A byte finishing on the tick cycle is folded straight into cmd so it
    // is not deferred a whole tick period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 8'h00;
            cmd     <= 8'h00;
        end else if (tick) begin
            cmd     <= pending | decode_now;
            pending <= 8'h00;
        end else begin
            pending <= pending | decode_now;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic       tick;
    logic [7:0] byte_o;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] cmd;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_ferr   = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_byte;
        logic [7:0] exp_cmd;
    } vec_t;

    vec_t vecs[12];

    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .tick       (tick),
        .byte_o     (byte_o),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .cmd        (cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) n_valid++;
        if (frame_err)  n_ferr++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // All stimulus tasks are entered and left at a falling clock edge.
    task automatic send_body(input logic [7:0] d);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_body(d);
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    int         bv;
    int         bf;
    logic [7:0] prev_cmd;

    initial begin
        vecs[0]  = '{8'h66, 1'b1, 1, 0, 8'h66, 8'h01};
        vecs[1]  = '{8'h7A, 1'b1, 1, 0, 8'h7A, 8'h00};
        vecs[2]  = '{8'h31, 1'b0, 0, 1, 8'h7A, 8'h00};
        vecs[3]  = '{8'h20, 1'b1, 1, 0, 8'h20, 8'h04};
        vecs[4]  = '{8'h73, 1'b1, 1, 0, 8'h73, 8'h08};
        vecs[5]  = '{8'h33, 1'b1, 1, 0, 8'h33, 8'h10};
        vecs[6]  = '{8'h32, 1'b1, 1, 0, 8'h32, 8'h20};
        vecs[7]  = '{8'h31, 1'b1, 1, 0, 8'h31, 8'h40};
        vecs[8]  = '{8'h6C, 1'b1, 1, 0, 8'h6C, 8'h80};
        vecs[9]  = '{8'h61, 1'b1, 1, 0, 8'h61, 8'h02};
        vecs[10] = '{8'h00, 1'b1, 1, 0, 8'h00, 8'h00};
        vecs[11] = '{8'hFF, 1'b1, 1, 0, 8'hFF, 8'h00};

        rst_n = 1'b0;
        rxd   = 1'b1;
        tick  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_byte_o", byte_o, 8'h00);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_cmd", cmd, 8'h00);
        repeat (4) @(negedge clk);

        // two keys between ticks accumulate
        send_frame(8'h66, 1'b1);
        send_frame(8'h6C, 1'b1);
        check("acc_hold", cmd, 8'h00);
        do_tick();
        check("acc_cmd", cmd, 8'h81);
        repeat (20) @(negedge clk);
        check("acc_held", cmd, 8'h81);
        do_tick();
        check("acc_clear", cmd, 8'h00);
        prev_cmd = 8'h00;

        for (int i = 0; i < 12; i++) begin
            bv = n_valid;
            bf = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop);
            check($sformatf("v%0d_valid", i), n_valid - bv, vecs[i].exp_valid);
            check($sformatf("v%0d_ferr", i), n_ferr - bf, vecs[i].exp_ferr);
            check($sformatf("v%0d_byte", i), byte_o, vecs[i].exp_byte);
            check($sformatf("v%0d_hold", i), cmd, prev_cmd);
            do_tick();
            check($sformatf("v%0d_cmd", i), cmd, vecs[i].exp_cmd);
            prev_cmd = vecs[i].exp_cmd;
        end

        // framing error followed by a 40-bit break
        bv = n_valid;
        bf = n_ferr;
        send_body(8'h31);
        rxd = 1'b0;
        repeat (41 * CPB) @(negedge clk);
        check("brk_ferr", n_ferr - bf, 1);
        check("brk_valid", n_valid - bv, 0);
        check("brk_byte", byte_o, 8'hFF);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("brk_ferr_after", n_ferr - bf, 1);
        check("brk_valid_after", n_valid - bv, 0);
        do_tick();
        check("brk_cmd", cmd, 8'h00);

        // short low glitch is rejected, next byte still received
        bv = n_valid;
        bf = n_ferr;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("gl_valid", n_valid - bv, 0);
        check("gl_ferr", n_ferr - bf, 0);
        send_frame(8'h20, 1'b1);
        check("gl_next_valid", n_valid - bv, 1);
        check("gl_next_byte", byte_o, 8'h20);
        do_tick();
        check("gl_next_cmd", cmd, 8'h04);

        // tick coincident with byte_valid: stop sample lands 155 cycles after
        // the start edge, so byte_valid is high from the 155th negedge on
        send_body(8'h61);
        rxd = 1'b1;
        repeat (11) @(negedge clk);
        check("co_valid_now", byte_valid, 1'b1);
        check("co_cmd_before", cmd, 8'h04);
        do_tick();
        check("co_cmd", cmd, 8'h02);
        repeat (2 * CPB) @(negedge clk);
        do_tick();
        check("co_no_double", cmd, 8'h00);

        send_frame(8'h61, 1'b1);
        do_tick();
        check("pre_rst_cmd", cmd, 8'h02);

        // reset in the middle of data bit 3
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'(8'h73 >> i);
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("mr_byte_o", byte_o, 8'h00);
        check("mr_byte_valid", byte_valid, 1'b0);
        check("mr_frame_err", frame_err, 1'b0);
        check("mr_cmd", cmd, 8'h00);
        bv = n_valid;
        bf = n_ferr;
        repeat (12 * CPB) @(negedge clk);
        check("mr_quiet_valid", n_valid - bv, 0);
        check("mr_quiet_ferr", n_ferr - bf, 0);
        send_frame(8'h32, 1'b1);
        check("mr_byte", byte_o, 8'h32);
        check("mr_hold", cmd, 8'h00);
        do_tick();
        check("mr_cmd_after", cmd, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
